// File: rtl/mem_stage_pkg.sv
// Shared types and defaults for the memory stage: FSM state encoding,
// default geometry/latency constants and the RAM address-window check.
package mem_stage_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int          DEF_WAIT_CYCLES = 4;
    localparam int          DEF_DEPTH       = 64;
    localparam logic [31:0] DEF_BASE_ADDR   = 32'd1024;

    // True when addr falls inside [base, base + 4*depth_words).
    // The subtraction wraps for addresses below base, which then fail the compare.
    function automatic logic addr_in_range(input logic [31:0] addr,
                                           input logic [31:0] base,
                                           input logic [31:0] depth_words);
        logic [31:0] off;
        off = addr - base;
        return (off < (depth_words << 2));
    endfunction

endpackage

// File: rtl/mem_stage_data_ram.sv
// Single-port DEPTH x 32 data RAM: synchronous write, combinational read,
// contents are never reset.
module data_ram
    import mem_stage_pkg::*;
#(
    parameter int DEPTH = DEF_DEPTH,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_addr,
    input  logic [31:0]   i_wdata,
    output logic [31:0]   o_rdata
);

    logic [31:0] r_mem [DEPTH];

    // Word write on the rising edge when enabled.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_addr];

endmodule

// File: rtl/mem_stage.sv
// Pipeline memory stage: multi-cycle word load/store into a local data RAM,
// freezing upstream via ready while an access is in flight.
// Optional macro MEM_STAGE_ACCESS_ERR_EN adds the access_err output.
//
// state   | meaning
// --------+---------------------------------------------------------------
// IDLE    | no access in flight; ready follows !req
// BUSY    | waiting out the RAM latency, counter counts down to 0
// DONE    | access completes on this edge (write RAM / capture load data)
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int          WAIT_CYCLES = DEF_WAIT_CYCLES,
    parameter int          DEPTH       = DEF_DEPTH,
    parameter logic [31:0] BASE_ADDR   = DEF_BASE_ADDR
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        MEM_R_EN,
    input  logic        MEM_W_EN,
    input  logic [31:0] ALU_result,
    input  logic [31:0] Val_Rm,
    output logic [31:0] mem_result,
    output logic        ready
`ifdef MEM_STAGE_ACCESS_ERR_EN
    ,
    output logic        access_err
`endif
);

    localparam int         AW         = $clog2(DEPTH);
    localparam logic [3:0] COUNT_INIT = (WAIT_CYCLES > 1) ? 4'(WAIT_CYCLES - 2) : 4'd0;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [3:0]  r_count;
    logic [3:0]  w_count_nxt;
    logic [31:0] r_mem_result;

    logic          w_req;
    logic          w_in_range;
    logic [31:0]   w_offset;
    logic [AW-1:0] w_index;
    logic [31:0]   w_rdata;
    logic          w_we;
    logic          w_do_load;

    assign w_req      = MEM_R_EN | MEM_W_EN;
    assign w_offset   = ALU_result - BASE_ADDR;
    assign w_index    = AW'(w_offset >> 2);
    assign w_in_range = addr_in_range(ALU_result, BASE_ADDR, 32'(DEPTH));

    // A store wins over a load when both enables are set; rst aborts the write.
    assign w_we      = (r_state == ST_DONE) && MEM_W_EN && w_in_range && !rst;
    assign w_do_load = (r_state == ST_DONE) && MEM_R_EN && !MEM_W_EN;

    data_ram #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_data_ram (
        .clk     (clk),
        .i_we    (w_we),
        .i_addr  (w_index),
        .i_wdata (Val_Rm),
        .o_rdata (w_rdata)
    );

    // State and latency counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_count <= 4'd0;
        end else begin
            r_state <= w_state_nxt;
            r_count <= w_count_nxt;
        end
    end

    // Next-state, counter and ready decode.
    always_comb begin
        w_state_nxt = r_state;
        w_count_nxt = r_count;
        ready       = 1'b1;
        case (r_state)
            ST_IDLE: begin
                if (w_req) begin
                    ready = 1'b0;
                    if (WAIT_CYCLES == 1) begin
                        w_state_nxt = ST_DONE;
                    end else begin
                        w_state_nxt = ST_BUSY;
                        w_count_nxt = COUNT_INIT;
                    end
                end
            end
            ST_BUSY: begin
                ready = 1'b0;
                if (r_count == 4'd0) begin
                    w_state_nxt = ST_DONE;
                end else begin
                    w_count_nxt = r_count - 4'd1;
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Load data capture; out-of-range loads return zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mem_result <= 32'd0;
        end else if (w_do_load) begin
            r_mem_result <= w_in_range ? w_rdata : 32'd0;
        end
    end

    assign mem_result = r_mem_result;

`ifdef MEM_STAGE_ACCESS_ERR_EN
    // Flag out-of-window or misaligned accesses for their DONE cycle only.
    assign access_err = (r_state == ST_DONE) && w_req &&
                        (!w_in_range || (ALU_result[1:0] != 2'b00));
`endif

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed scenarios plus randomized
// load/store traffic against an array-based reference memory.
module tb_mem_stage;

    localparam int          WAIT  = 4;
    localparam int          DEPTH = 64;
    localparam logic [31:0] BASE  = 32'd1024;

    logic        clk = 1'b0;
    logic        rst;
    logic        MEM_R_EN, MEM_W_EN;
    logic [31:0] ALU_result, Val_Rm;
    logic [31:0] mem_result;
    logic        ready;

    logic        r1, w1;
    logic [31:0] a1, d1;
    logic [31:0] res1;
    logic        ready1;

`ifdef MEM_STAGE_ACCESS_ERR_EN
    logic        access_err;
    logic        access_err1;
`endif

    int checks   = 0;
    int failures = 0;

    logic [31:0] model_mem [DEPTH];
    logic [31:0] exp_result = 32'd0;

    always #5 clk = ~clk;

    mem_stage #(.WAIT_CYCLES(WAIT), .DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
        .clk        (clk),
        .rst        (rst),
        .MEM_R_EN   (MEM_R_EN),
        .MEM_W_EN   (MEM_W_EN),
        .ALU_result (ALU_result),
        .Val_Rm     (Val_Rm),
        .mem_result (mem_result),
        .ready      (ready)
`ifdef MEM_STAGE_ACCESS_ERR_EN
        ,
        .access_err (access_err)
`endif
    );

    mem_stage #(.WAIT_CYCLES(1), .DEPTH(16), .BASE_ADDR(BASE)) dut1 (
        .clk        (clk),
        .rst        (rst),
        .MEM_R_EN   (r1),
        .MEM_W_EN   (w1),
        .ALU_result (a1),
        .Val_Rm     (d1),
        .mem_result (res1),
        .ready      (ready1)
`ifdef MEM_STAGE_ACCESS_ERR_EN
        ,
        .access_err (access_err1)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic bit model_in_range(input logic [31:0] a);
        longint unsigned v;
        v = longint'(a);
        return (v >= longint'(BASE)) && (v < longint'(BASE) + 4 * DEPTH);
    endfunction

    function automatic int model_index(input logic [31:0] a);
        return int'((longint'(a) - longint'(BASE)) / 4);
    endfunction

    // One complete access: count stall cycles, then check result at IDLE.
    task automatic access(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d);
        int stall;
        bit inr;
        stall = 0;
        inr   = model_in_range(a);
        @(negedge clk);
        MEM_R_EN = r; MEM_W_EN = w; ALU_result = a; Val_Rm = d;
        #1;
        while (ready !== 1'b1 && stall < 40) begin
            stall++;
            @(negedge clk);
            #1;
        end
        chk("stall_cycles", 32'(stall), 32'(WAIT));
`ifdef MEM_STAGE_ACCESS_ERR_EN
        chk("access_err", {31'd0, access_err}, {31'd0, (!inr || a[1:0] != 2'b00)});
`endif
        if (w) begin
            if (inr) model_mem[model_index(a)] = d;
        end else if (r) begin
            exp_result = inr ? model_mem[model_index(a)] : 32'd0;
        end
        @(negedge clk);
        MEM_R_EN = 1'b0; MEM_W_EN = 1'b0;
        #1;
        chk("mem_result", mem_result, exp_result);
        chk("ready_after", {31'd0, ready}, 32'd1);
    endtask

    initial begin
        logic [31:0] addr;
        int sel;
        int op;

        rst = 1'b1;
        MEM_R_EN = 1'b0; MEM_W_EN = 1'b0; ALU_result = 32'd0; Val_Rm = 32'd0;
        r1 = 1'b0; w1 = 1'b0; a1 = 32'd0; d1 = 32'd0;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Idle: no request for 10 cycles
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            #1;
            chk("idle_ready", {31'd0, ready}, 32'd1);
            chk("idle_result", mem_result, 32'd0);
        end

        // Store then load at the base address
        access(1'b0, 1'b1, 32'd1024, 32'hDEADBEEF);
        access(1'b1, 1'b0, 32'd1024, 32'd0);
        chk("deadbeef", mem_result, 32'hDEADBEEF);

        // Neighbour in range and just below the window
        access(1'b0, 1'b1, 32'd1028, 32'hCAFE0001);
        access(1'b0, 1'b1, 32'd1020, 32'h0BADF00D);
        access(1'b1, 1'b0, 32'd1028, 32'd0);
        access(1'b1, 1'b0, 32'd1020, 32'd0);

        // Reset during BUSY aborts the store
        @(negedge clk);
        MEM_W_EN = 1'b1; ALU_result = 32'd1024; Val_Rm = 32'h11;
        @(negedge clk);
        rst = 1'b1; MEM_W_EN = 1'b0;
        @(negedge clk);
        #1;
        chk("rst_ready", {31'd0, ready}, 32'd1);
        chk("rst_result", mem_result, 32'd0);
        rst = 1'b0;
        exp_result = 32'd0;
        access(1'b1, 1'b0, 32'd1024, 32'd0);
        chk("rst_abort", mem_result, 32'hDEADBEEF);

        // Last word and first word past the window
        access(1'b0, 1'b1, BASE + 4 * DEPTH - 4, 32'h5A5A5A5A);
        access(1'b1, 1'b0, BASE + 4 * DEPTH - 4, 32'd0);
        chk("last_word", mem_result, 32'h5A5A5A5A);
        access(1'b1, 1'b0, BASE + 4 * DEPTH, 32'd0);
        chk("past_end", mem_result, 32'd0);

        // Single-cycle latency instance: store, then a held load
        @(negedge clk);
        w1 = 1'b1; a1 = 32'd1024; d1 = 32'h12345678;
        #1;
        chk("w1_stall", {31'd0, ready1}, 32'd0);
        @(negedge clk);
        #1;
        chk("w1_done", {31'd0, ready1}, 32'd1);
        @(negedge clk);
        w1 = 1'b0; r1 = 1'b1;
        #1;
        chk("w1_load_stall", {31'd0, ready1}, 32'd0);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            #1;
            chk("w1_ready_alt", {31'd0, ready1}, (k % 2 == 0) ? 32'd1 : 32'd0);
            if (k >= 1) chk("w1_result", res1, 32'h12345678);
        end
        r1 = 1'b0;

        // Fill every word, then random traffic
        for (int i = 0; i < DEPTH; i++) begin
            access(1'b0, 1'b1, BASE + 32'(4 * i), $urandom);
        end
        for (int n = 0; n < 40; n++) begin
            sel = $urandom_range(0, 4);
            case (sel)
                0: addr = BASE + 32'(4 * $urandom_range(0, DEPTH - 1));
                1: addr = BASE + 32'(4 * $urandom_range(0, DEPTH - 1)) + 32'($urandom_range(1, 3));
                2: addr = BASE - 32'(4 * $urandom_range(1, 8));
                3: addr = BASE + 32'(4 * DEPTH) + 32'($urandom_range(0, 64));
                default: addr = $urandom;
            endcase
            op = $urandom_range(1, 3);
            access(op[0], op[1], addr, $urandom);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
